axi_slice_dc_master: RTL and testbench

Master-side half of the dual-clock AXI slice. It sits in the target clock domain and turns the token-ring streams from the slave-side half into a standard AXI4 master port. For AW, AR and W it is the ring consumer: it synchronises the remote write token, presents valid and payload, and advances its read pointer. For R and B it is the ring producer: it owns the buffer, accepts valid/ready handshakes and advances its write token.

---
 rtl/axi_slice_dc_pkg.sv | 51 +++++
 rtl/dc_token_ring_consumer.sv | 39 +++
 rtl/dc_token_ring_producer.sv | 59 +++++
 rtl/axi_slice_dc_master.sv | 152 +++++++++++++++
 tb/tb_axi_slice_dc_master.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_slice_dc_pkg.sv
// Shared definitions for both halves of the dual-clock AXI slice.
// Holds the bit layout of each channel's ring word, width helpers for the
// ring words, and the one-hot rotate used to advance pointers and tokens.
package axi_slice_dc_pkg;

  // AW/AR word: fixed-width control fields first, then addr, id, user.
  localparam int AX_CACHE_LSB  = 0;
  localparam int AX_PROT_LSB   = 4;
  localparam int AX_LOCK_LSB   = 7;   // two bits reserved, only bit 7 is driven out
  localparam int AX_BURST_LSB  = 9;
  localparam int AX_SIZE_LSB   = 11;
  localparam int AX_LEN_LSB    = 14;
  localparam int AX_REGION_LSB = 22;
  localparam int AX_QOS_LSB    = 26;
  localparam int AX_ADDR_LSB   = 30;
  // W word: last, data, strb, user.
  localparam int W_DATA_LSB    = 1;
  // R word: last, resp, data, id, user.
  localparam int R_RESP_LSB    = 1;
  localparam int R_DATA_LSB    = 3;
  // B word: resp, id, user.
  localparam int B_ID_LSB      = 2;

  function automatic int fifo_w_ax(input int aw, input int iw, input int uw);
    return AX_ADDR_LSB + aw + iw + uw;
  endfunction
  function automatic int fifo_w_w(input int dw, input int uw);
    return W_DATA_LSB + dw + dw / 8 + uw;
  endfunction
  function automatic int fifo_w_r(input int dw, input int iw, input int uw);
    return R_DATA_LSB + dw + iw + uw;
  endfunction
  function automatic int fifo_w_b(input int iw, input int uw);
    return B_ID_LSB + iw + uw;
  endfunction

  // Ring word widths for the default AXI geometry (32/64/6/6).
  localparam int WIDTH_FIFO_AW = fifo_w_ax(32, 6, 6);
  localparam int WIDTH_FIFO_AR = fifo_w_ax(32, 6, 6);
  localparam int WIDTH_FIFO_W  = fifo_w_w(64, 6);
  localparam int WIDTH_FIFO_R  = fifo_w_r(64, 6, 6);
  localparam int WIDTH_FIFO_B  = fifo_w_b(6, 6);

  // Rotate the low n bits of v left by one; bit n-1 wraps to bit 0. n <= 32.
  function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned n);
    logic [31:0] mask;
    mask = (n >= 32) ? '1 : ((32'd1 << n) - 32'd1);
    return ((v << 1) | (v >> (n - 1))) & mask;
  endfunction

endpackage

// File: rtl/dc_token_ring_consumer.sv
// Read side of a token ring crossing into the local clock.
// i_writetoken  : remote one-hot write token (foreign clock)
// i_ready       : local sink accepts the presented entry
// o_valid       : ring non-empty as seen through the synchroniser
// o_readpointer : local one-hot read pointer, selects the remote slot
module dc_token_ring_consumer
  import axi_slice_dc_pkg::*;
#(
  parameter int BUFFER_WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [BUFFER_WIDTH-1:0] i_writetoken,
  input  logic                    i_ready,
  output logic                    o_valid,
  output logic [BUFFER_WIDTH-1:0] o_readpointer
);
  localparam logic [BUFFER_WIDTH-1:0] PTR_RST = BUFFER_WIDTH'(1);

  logic [BUFFER_WIDTH-1:0] r_sync1, r_sync2, r_rptr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync1 <= PTR_RST;
      r_sync2 <= PTR_RST;
      r_rptr  <= PTR_RST;
    end else begin
      r_sync1 <= i_writetoken;
      r_sync2 <= r_sync1;
      if (o_valid && i_ready)
        r_rptr <= BUFFER_WIDTH'(rotl(32'(r_rptr), BUFFER_WIDTH));
    end
  end

  // One-hot token only moves one bit at a time, so a stale synchronised
  // value can only under-report occupancy, never over-report it.
  assign o_valid       = (r_sync2 != r_rptr);
  assign o_readpointer = r_rptr;
endmodule

// File: rtl/dc_token_ring_producer.sv
// Write side of a token ring, owning the buffer in the local clock.
// i_valid/i_data : local source handshake and packed word
// o_ready        : ring not full as seen through the synchroniser
// i_readpointer  : remote one-hot read pointer (foreign clock)
// o_writetoken   : local one-hot write token
// o_data_async   : buffer slot selected by the remote read pointer
module dc_token_ring_producer
  import axi_slice_dc_pkg::*;
#(
  parameter int BUFFER_WIDTH = 8,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    i_valid,
  input  logic [DATA_WIDTH-1:0]   i_data,
  output logic                    o_ready,
  input  logic [BUFFER_WIDTH-1:0] i_readpointer,
  output logic [BUFFER_WIDTH-1:0] o_writetoken,
  output logic [DATA_WIDTH-1:0]   o_data_async
);
  localparam logic [BUFFER_WIDTH-1:0] PTR_RST = BUFFER_WIDTH'(1);

  logic [BUFFER_WIDTH-1:0][DATA_WIDTH-1:0] r_buf;
  logic [BUFFER_WIDTH-1:0] r_sync1, r_sync2, r_wtok;
  logic [BUFFER_WIDTH-1:0] w_wtok_nxt;
  logic [DATA_WIDTH-1:0]   w_mux;

  assign w_wtok_nxt = BUFFER_WIDTH'(rotl(32'(r_wtok), BUFFER_WIDTH));
  // Keep one slot empty: the token may never land on the reader's slot.
  assign o_ready    = (w_wtok_nxt != r_sync2);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_buf   <= '0;
      r_sync1 <= PTR_RST;
      r_sync2 <= PTR_RST;
      r_wtok  <= PTR_RST;
    end else begin
      r_sync1 <= i_readpointer;
      r_sync2 <= r_sync1;
      if (i_valid && o_ready) begin
        for (int i = 0; i < BUFFER_WIDTH; i++)
          if (r_wtok[i]) r_buf[i] <= i_data;
        r_wtok <= w_wtok_nxt;
      end
    end
  end

  always_comb begin
    w_mux = '0;
    for (int i = 0; i < BUFFER_WIDTH; i++)
      if (i_readpointer[i]) w_mux = w_mux | r_buf[i];
    // A malformed pointer reads as zero rather than an OR of slots.
    o_data_async = $onehot(i_readpointer) ? w_mux : '0;
  end

  assign o_writetoken = r_wtok;
endmodule

// File: rtl/axi_slice_dc_master.sv
// Master-side half of the dual-clock AXI slice (target clock domain).
// AW/AR/W: ring consumers; remote slot + write token in, read pointer out,
//          unpacked onto the AXI4 master request channels.
// R/B:     ring producers; AXI4 responses packed into the local buffer,
//          write token and pointer-selected slot out to the slave half.
module axi_slice_dc_master
  import axi_slice_dc_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_USER_WIDTH = 6,
  parameter int AXI_ID_WIDTH   = 6,
  parameter int BUFFER_WIDTH   = 8,
  localparam int LP_W_AX = fifo_w_ax(AXI_ADDR_WIDTH, AXI_ID_WIDTH, AXI_USER_WIDTH),
  localparam int LP_W_W  = fifo_w_w(AXI_DATA_WIDTH, AXI_USER_WIDTH),
  localparam int LP_W_R  = fifo_w_r(AXI_DATA_WIDTH, AXI_ID_WIDTH, AXI_USER_WIDTH),
  localparam int LP_W_B  = fifo_w_b(AXI_ID_WIDTH, AXI_USER_WIDTH)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [LP_W_AX-1:0]          axi_slave_aw_data_async,
  input  logic [BUFFER_WIDTH-1:0]     axi_slave_aw_writetoken,
  output logic [BUFFER_WIDTH-1:0]     axi_slave_aw_readpointer,
  input  logic [LP_W_AX-1:0]          axi_slave_ar_data_async,
  input  logic [BUFFER_WIDTH-1:0]     axi_slave_ar_writetoken,
  output logic [BUFFER_WIDTH-1:0]     axi_slave_ar_readpointer,
  input  logic [LP_W_W-1:0]           axi_slave_w_data_async,
  input  logic [BUFFER_WIDTH-1:0]     axi_slave_w_writetoken,
  output logic [BUFFER_WIDTH-1:0]     axi_slave_w_readpointer,
  output logic [LP_W_R-1:0]           axi_slave_r_data_async,
  output logic [BUFFER_WIDTH-1:0]     axi_slave_r_writetoken,
  input  logic [BUFFER_WIDTH-1:0]     axi_slave_r_readpointer,
  output logic [LP_W_B-1:0]           axi_slave_b_data_async,
  output logic [BUFFER_WIDTH-1:0]     axi_slave_b_writetoken,
  input  logic [BUFFER_WIDTH-1:0]     axi_slave_b_readpointer,
  output logic                        axi_master_aw_valid,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_master_aw_addr,
  output logic [2:0]                  axi_master_aw_prot,
  output logic [3:0]                  axi_master_aw_region,
  output logic [7:0]                  axi_master_aw_len,
  output logic [2:0]                  axi_master_aw_size,
  output logic [1:0]                  axi_master_aw_burst,
  output logic                        axi_master_aw_lock,
  output logic [3:0]                  axi_master_aw_cache,
  output logic [3:0]                  axi_master_aw_qos,
  output logic [AXI_ID_WIDTH-1:0]     axi_master_aw_id,
  output logic [AXI_USER_WIDTH-1:0]   axi_master_aw_user,
  input  logic                        axi_master_aw_ready,
  output logic                        axi_master_ar_valid,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_master_ar_addr,
  output logic [2:0]                  axi_master_ar_prot,
  output logic [3:0]                  axi_master_ar_region,
  output logic [7:0]                  axi_master_ar_len,
  output logic [2:0]                  axi_master_ar_size,
  output logic [1:0]                  axi_master_ar_burst,
  output logic                        axi_master_ar_lock,
  output logic [3:0]                  axi_master_ar_cache,
  output logic [3:0]                  axi_master_ar_qos,
  output logic [AXI_ID_WIDTH-1:0]     axi_master_ar_id,
  output logic [AXI_USER_WIDTH-1:0]   axi_master_ar_user,
  input  logic                        axi_master_ar_ready,
  output logic                        axi_master_w_valid,
  output logic [AXI_DATA_WIDTH-1:0]   axi_master_w_data,
  output logic [AXI_DATA_WIDTH/8-1:0] axi_master_w_strb,
  output logic [AXI_USER_WIDTH-1:0]   axi_master_w_user,
  output logic                        axi_master_w_last,
  input  logic                        axi_master_w_ready,
  input  logic                        axi_master_r_valid,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_master_r_data,
  input  logic [1:0]                  axi_master_r_resp,
  input  logic                        axi_master_r_last,
  input  logic [AXI_ID_WIDTH-1:0]     axi_master_r_id,
  input  logic [AXI_USER_WIDTH-1:0]   axi_master_r_user,
  output logic                        axi_master_r_ready,
  input  logic                        axi_master_b_valid,
  input  logic [1:0]                  axi_master_b_resp,
  input  logic [AXI_ID_WIDTH-1:0]     axi_master_b_id,
  input  logic [AXI_USER_WIDTH-1:0]   axi_master_b_user,
  output logic                        axi_master_b_ready
);
  localparam int AX_ID_LSB   = AX_ADDR_LSB + AXI_ADDR_WIDTH;
  localparam int AX_USER_LSB = AX_ID_LSB + AXI_ID_WIDTH;
  localparam int W_STRB_LSB  = W_DATA_LSB + AXI_DATA_WIDTH;
  localparam int W_USER_LSB  = W_STRB_LSB + AXI_DATA_WIDTH / 8;

  logic [LP_W_R-1:0] w_r_word;
  logic [LP_W_B-1:0] w_b_word;
  // Upper lock bit is carried in the ring word but has no AXI4 destination.
  logic [1:0]        w_unused_lock;

  assign w_unused_lock = {axi_slave_aw_data_async[AX_LOCK_LSB+1],
                          axi_slave_ar_data_async[AX_LOCK_LSB+1]};

  // AW unpack
  assign axi_master_aw_cache  = axi_slave_aw_data_async[AX_CACHE_LSB  +: 4];
  assign axi_master_aw_prot   = axi_slave_aw_data_async[AX_PROT_LSB   +: 3];
  assign axi_master_aw_lock   = axi_slave_aw_data_async[AX_LOCK_LSB];
  assign axi_master_aw_burst  = axi_slave_aw_data_async[AX_BURST_LSB  +: 2];
  assign axi_master_aw_size   = axi_slave_aw_data_async[AX_SIZE_LSB   +: 3];
  assign axi_master_aw_len    = axi_slave_aw_data_async[AX_LEN_LSB    +: 8];
  assign axi_master_aw_region = axi_slave_aw_data_async[AX_REGION_LSB +: 4];
  assign axi_master_aw_qos    = axi_slave_aw_data_async[AX_QOS_LSB    +: 4];
  assign axi_master_aw_addr   = axi_slave_aw_data_async[AX_ADDR_LSB   +: AXI_ADDR_WIDTH];
  assign axi_master_aw_id     = axi_slave_aw_data_async[AX_ID_LSB     +: AXI_ID_WIDTH];
  assign axi_master_aw_user   = axi_slave_aw_data_async[AX_USER_LSB   +: AXI_USER_WIDTH];

  // AR unpack
  assign axi_master_ar_cache  = axi_slave_ar_data_async[AX_CACHE_LSB  +: 4];
  assign axi_master_ar_prot   = axi_slave_ar_data_async[AX_PROT_LSB   +: 3];
  assign axi_master_ar_lock   = axi_slave_ar_data_async[AX_LOCK_LSB];
  assign axi_master_ar_burst  = axi_slave_ar_data_async[AX_BURST_LSB  +: 2];
  assign axi_master_ar_size   = axi_slave_ar_data_async[AX_SIZE_LSB   +: 3];
  assign axi_master_ar_len    = axi_slave_ar_data_async[AX_LEN_LSB    +: 8];
  assign axi_master_ar_region = axi_slave_ar_data_async[AX_REGION_LSB +: 4];
  assign axi_master_ar_qos    = axi_slave_ar_data_async[AX_QOS_LSB    +: 4];
  assign axi_master_ar_addr   = axi_slave_ar_data_async[AX_ADDR_LSB   +: AXI_ADDR_WIDTH];
  assign axi_master_ar_id     = axi_slave_ar_data_async[AX_ID_LSB     +: AXI_ID_WIDTH];
  assign axi_master_ar_user   = axi_slave_ar_data_async[AX_USER_LSB   +: AXI_USER_WIDTH];

  // W unpack
  assign axi_master_w_last = axi_slave_w_data_async[0];
  assign axi_master_w_data = axi_slave_w_data_async[W_DATA_LSB +: AXI_DATA_WIDTH];
  assign axi_master_w_strb = axi_slave_w_data_async[W_STRB_LSB +: AXI_DATA_WIDTH/8];
  assign axi_master_w_user = axi_slave_w_data_async[W_USER_LSB +: AXI_USER_WIDTH];

  // R/B pack, LSB first
  assign w_r_word = {axi_master_r_user, axi_master_r_id, axi_master_r_data,
                     axi_master_r_resp, axi_master_r_last};
  assign w_b_word = {axi_master_b_user, axi_master_b_id, axi_master_b_resp};

  dc_token_ring_consumer #(.BUFFER_WIDTH(BUFFER_WIDTH)) u_aw (
    .clk_i, .rst_ni, .i_writetoken(axi_slave_aw_writetoken), .i_ready(axi_master_aw_ready),
    .o_valid(axi_master_aw_valid), .o_readpointer(axi_slave_aw_readpointer));

  dc_token_ring_consumer #(.BUFFER_WIDTH(BUFFER_WIDTH)) u_ar (
    .clk_i, .rst_ni, .i_writetoken(axi_slave_ar_writetoken), .i_ready(axi_master_ar_ready),
    .o_valid(axi_master_ar_valid), .o_readpointer(axi_slave_ar_readpointer));

  dc_token_ring_consumer #(.BUFFER_WIDTH(BUFFER_WIDTH)) u_w (
    .clk_i, .rst_ni, .i_writetoken(axi_slave_w_writetoken), .i_ready(axi_master_w_ready),
    .o_valid(axi_master_w_valid), .o_readpointer(axi_slave_w_readpointer));

  dc_token_ring_producer #(.BUFFER_WIDTH(BUFFER_WIDTH), .DATA_WIDTH(LP_W_R)) u_r (
    .clk_i, .rst_ni, .i_valid(axi_master_r_valid), .i_data(w_r_word),
    .o_ready(axi_master_r_ready), .i_readpointer(axi_slave_r_readpointer),
    .o_writetoken(axi_slave_r_writetoken), .o_data_async(axi_slave_r_data_async));

  dc_token_ring_producer #(.BUFFER_WIDTH(BUFFER_WIDTH), .DATA_WIDTH(LP_W_B)) u_b (
    .clk_i, .rst_ni, .i_valid(axi_master_b_valid), .i_data(w_b_word),
    .o_ready(axi_master_b_ready), .i_readpointer(axi_slave_b_readpointer),
    .o_writetoken(axi_slave_b_writetoken), .o_data_async(axi_slave_b_data_async));
endmodule

// File: tb/tb_axi_slice_dc_master.sv
module tb_axi_slice_dc_master;
  // Ring word widths for the default geometry, computed by hand:
  // AX = 30+32+6+6, W = 1+64+8+6, R = 3+64+6+6, B = 2+6+6
  localparam int WAX = 74, WW = 79, WR = 79, WB = 14;

  logic clk = 1'b0, rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic [WAX-1:0] aw_da, ar_da;
  logic [WW-1:0]  w_da;
  logic [WR-1:0]  r_da;
  logic [WB-1:0]  b_da;
  logic [7:0] aw_wt, ar_wt, w_wt, aw_rp, ar_rp, w_rp, r_wt, b_wt, r_rp, b_rp;
  logic aw_valid, aw_ready, aw_lock, ar_valid, ar_ready, ar_lock;
  logic [31:0] aw_addr, ar_addr;
  logic [2:0] aw_prot, aw_size, ar_prot, ar_size;
  logic [3:0] aw_region, aw_cache, aw_qos, ar_region, ar_cache, ar_qos;
  logic [7:0] aw_len, ar_len, w_strb;
  logic [1:0] aw_burst, ar_burst, r_resp, b_resp;
  logic [5:0] aw_id, aw_user, ar_id, ar_user, w_user, r_id, r_user, b_id, b_user;
  logic w_valid, w_ready, w_last, r_valid, r_last, r_ready, b_valid, b_ready;
  logic [63:0] w_data, r_data;

  int n_tests = 0, n_fail = 0;

  // Remote W buffer model: slot selected by the DUT's read pointer.
  logic [WW-1:0] w_mem [8];
  always_comb begin
    w_da = '0;
    for (int i = 0; i < 8; i++) if (w_rp[i]) w_da = w_mem[i];
  end

  axi_slice_dc_master dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .axi_slave_aw_data_async(aw_da), .axi_slave_aw_writetoken(aw_wt), .axi_slave_aw_readpointer(aw_rp),
    .axi_slave_ar_data_async(ar_da), .axi_slave_ar_writetoken(ar_wt), .axi_slave_ar_readpointer(ar_rp),
    .axi_slave_w_data_async(w_da), .axi_slave_w_writetoken(w_wt), .axi_slave_w_readpointer(w_rp),
    .axi_slave_r_data_async(r_da), .axi_slave_r_writetoken(r_wt), .axi_slave_r_readpointer(r_rp),
    .axi_slave_b_data_async(b_da), .axi_slave_b_writetoken(b_wt), .axi_slave_b_readpointer(b_rp),
    .axi_master_aw_valid(aw_valid), .axi_master_aw_addr(aw_addr), .axi_master_aw_prot(aw_prot),
    .axi_master_aw_region(aw_region), .axi_master_aw_len(aw_len), .axi_master_aw_size(aw_size),
    .axi_master_aw_burst(aw_burst), .axi_master_aw_lock(aw_lock), .axi_master_aw_cache(aw_cache),
    .axi_master_aw_qos(aw_qos), .axi_master_aw_id(aw_id), .axi_master_aw_user(aw_user),
    .axi_master_aw_ready(aw_ready),
    .axi_master_ar_valid(ar_valid), .axi_master_ar_addr(ar_addr), .axi_master_ar_prot(ar_prot),
    .axi_master_ar_region(ar_region), .axi_master_ar_len(ar_len), .axi_master_ar_size(ar_size),
    .axi_master_ar_burst(ar_burst), .axi_master_ar_lock(ar_lock), .axi_master_ar_cache(ar_cache),
    .axi_master_ar_qos(ar_qos), .axi_master_ar_id(ar_id), .axi_master_ar_user(ar_user),
    .axi_master_ar_ready(ar_ready),
    .axi_master_w_valid(w_valid), .axi_master_w_data(w_data), .axi_master_w_strb(w_strb),
    .axi_master_w_user(w_user), .axi_master_w_last(w_last), .axi_master_w_ready(w_ready),
    .axi_master_r_valid(r_valid), .axi_master_r_data(r_data), .axi_master_r_resp(r_resp),
    .axi_master_r_last(r_last), .axi_master_r_id(r_id), .axi_master_r_user(r_user),
    .axi_master_r_ready(r_ready),
    .axi_master_b_valid(b_valid), .axi_master_b_resp(b_resp), .axi_master_b_id(b_id),
    .axi_master_b_user(b_user), .axi_master_b_ready(b_ready)
  );

  function automatic logic [7:0] rot8(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  // {user, id, addr, qos, region, len, size, burst, lock[1:0], prot, cache}
  function automatic logic [WAX-1:0] ax_word(input logic [31:0] addr, input logic [5:0] id,
      input logic [5:0] user, input logic [7:0] len, input logic [2:0] size,
      input logic [1:0] burst, input logic [1:0] lock2, input logic [3:0] cache,
      input logic [2:0] prot, input logic [3:0] region, input logic [3:0] qos);
    return {user, id, addr, qos, region, len, size, burst, lock2, prot, cache};
  endfunction

  task automatic test_reset();
    rst_ni = 1'b0;
    aw_wt = 8'h01; ar_wt = 8'h01; w_wt = 8'h01; r_rp = 8'h01; b_rp = 8'h01;
    aw_da = '0; ar_da = '0; aw_ready = 0; ar_ready = 0; w_ready = 0;
    r_valid = 0; r_data = '0; r_resp = '0; r_last = 0; r_id = '0; r_user = '0;
    b_valid = 0; b_resp = '0; b_id = '0; b_user = '0;
    for (int i = 0; i < 8; i++) w_mem[i] = '0;
    repeat (3) @(negedge clk);
    n_tests++; if ({aw_valid, ar_valid, w_valid} !== 3'b000) begin n_fail++;
      $display("FAIL reset_valid: got %b want 000", {aw_valid, ar_valid, w_valid}); end
    n_tests++; if ({aw_rp, ar_rp, w_rp} !== {3{8'h01}}) begin n_fail++;
      $display("FAIL reset_readptr: got %h want 010101", {aw_rp, ar_rp, w_rp}); end
    n_tests++; if ({r_wt, b_wt} !== {2{8'h01}}) begin n_fail++;
      $display("FAIL reset_wtoken: got %h want 0101", {r_wt, b_wt}); end
    rst_ni = 1'b1;
    @(posedge clk); @(negedge clk);
    n_tests++; if ({r_ready, b_ready} !== 2'b11) begin n_fail++;
      $display("FAIL reset_ready: got %b want 11", {r_ready, b_ready}); end
    n_tests++; if ({aw_valid, ar_valid, w_valid} !== 3'b000) begin n_fail++;
      $display("FAIL reset_valid_post: got %b want 000", {aw_valid, ar_valid, w_valid}); end
  endtask

  task automatic test_single_aw();
    // cache=3 prot=2 lock=01 burst=1 size=3 len=3 region=4 qos=7 user=9
    aw_da = ax_word(32'h1000_0040, 6'd5, 6'd9, 8'd3, 3'd3, 2'd1, 2'b01, 4'd3, 3'd2, 4'd4, 4'd7);
    aw_wt = 8'h02; aw_ready = 0;
    @(posedge clk); @(negedge clk);
    n_tests++; if (aw_valid !== 1'b0) begin n_fail++;
      $display("FAIL aw_valid_cycle1: got %b want 0", aw_valid); end
    @(posedge clk); @(negedge clk);
    n_tests++; if (aw_valid !== 1'b1) begin n_fail++;
      $display("FAIL aw_valid_cycle2: got %b want 1", aw_valid); end
    n_tests++; if (aw_addr !== 32'h1000_0040 || aw_len !== 8'd3 || aw_id !== 6'd5) begin n_fail++;
      $display("FAIL aw_addr_len_id: got %h/%0d/%0d want 10000040/3/5", aw_addr, aw_len, aw_id); end
    n_tests++;
    if ({aw_cache, aw_prot, aw_lock, aw_burst, aw_size, aw_region, aw_qos, aw_user}
        !== {4'd3, 3'd2, 1'b1, 2'd1, 3'd3, 4'd4, 4'd7, 6'd9}) begin n_fail++;
      $display("FAIL aw_fields: got c%0d p%0d l%0d b%0d s%0d r%0d q%0d u%0d want c3 p2 l1 b1 s3 r4 q7 u9",
               aw_cache, aw_prot, aw_lock, aw_burst, aw_size, aw_region, aw_qos, aw_user); end
    aw_ready = 1;
    @(posedge clk); @(negedge clk);
    aw_ready = 0;
    n_tests++; if (aw_rp !== 8'h02 || aw_valid !== 1'b0) begin n_fail++;
      $display("FAIL aw_advance: got rp=%h valid=%b want rp=02 valid=0", aw_rp, aw_valid); end
  endtask

  task automatic test_b_full();
    logic [7:0] tmp;
    b_rp = 8'h01;
    for (int i = 0; i < 7; i++) begin
      n_tests++; if (b_ready !== 1'b1) begin n_fail++;
        $display("FAIL b_ready_beat%0d: got %b want 1", i, b_ready); end
      b_valid = 1; b_resp = 2'(i); b_id = 6'(i + 1); b_user = 6'(i + 2);
      @(posedge clk); @(negedge clk);
    end
    b_valid = 0;
    n_tests++; if (b_ready !== 1'b0) begin n_fail++;
      $display("FAIL b_full_ready: got %b want 0", b_ready); end
    n_tests++; if (b_wt !== 8'h80) begin n_fail++;
      $display("FAIL b_full_token: got %h want 80", b_wt); end
    n_tests++; if (b_da !== {6'd2, 6'd1, 2'd0}) begin n_fail++;
      $display("FAIL b_slot0: got %h want %h", b_da, {6'd2, 6'd1, 2'd0}); end
    tmp = 8'h04; b_rp = tmp; #1;
    n_tests++; if (b_da !== {6'd4, 6'd3, 2'd2}) begin n_fail++;
      $display("FAIL b_slot2: got %h want %h", b_da, {6'd4, 6'd3, 2'd2}); end
    b_rp = 8'h03; #1;
    n_tests++; if (b_da !== '0) begin n_fail++;
      $display("FAIL b_multihot_ptr: got %h want 0", b_da); end
    b_rp = 8'h00; #1;
    n_tests++; if (b_da !== '0) begin n_fail++;
      $display("FAIL b_zero_ptr: got %h want 0", b_da); end
    b_rp = 8'h02;
    @(posedge clk); @(negedge clk);
    n_tests++; if (b_ready !== 1'b0) begin n_fail++;
      $display("FAIL b_reopen_early: got %b want 0", b_ready); end
    @(posedge clk); @(negedge clk);
    n_tests++; if (b_ready !== 1'b1) begin n_fail++;
      $display("FAIL b_reopen: got %b want 1", b_ready); end
  endtask

  task automatic test_r_wrap();
    logic [7:0] rp, etok;
    rp = 8'h01; etok = 8'h01; r_rp = rp;
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      n_tests++; if (r_ready !== 1'b1) begin n_fail++;
        $display("FAIL r_ready_beat%0d: got %b want 1", k, r_ready); end
      r_valid = 1; r_data = 64'(k); r_last = k[0]; r_resp = k[1:0];
      r_id = 6'(k + 3); r_user = 6'(k + 7);
      @(posedge clk); @(negedge clk);
      r_valid = 0; etok = rot8(etok); #1;
      n_tests++;
      if (r_da[66:3] !== 64'(k) || r_da[0] !== k[0] || r_da[2:1] !== k[1:0] ||
          r_da[72:67] !== 6'(k + 3) || r_da[78:73] !== 6'(k + 7)) begin n_fail++;
        $display("FAIL r_data_beat%0d: got %h want data %0d", k, r_da, k); end
      n_tests++; if (r_wt !== etok) begin n_fail++;
        $display("FAIL r_token_beat%0d: got %h want %h", k, r_wt, etok); end
      rp = rot8(rp); r_rp = rp;
    end
  endtask

  task automatic test_w_stall();
    for (int i = 0; i < 3; i++)
      w_mem[i] = {6'(i + 1), 8'hF0 | 8'(i), 64'hA000_0000_0000_00A0 + 64'(i), (i == 2)};
    w_ready = 0; w_wt = 8'h08;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      n_tests++; if (w_valid !== 1'b1 || w_data !== 64'hA000_0000_0000_00A0 || w_last !== 1'b0) begin
        n_fail++;
        $display("FAIL w_stall_c%0d: got v=%b d=%h l=%b want v=1 d=a0000000000000a0 l=0",
                 c, w_valid, w_data, w_last); end
      @(posedge clk); @(negedge clk);
    end
    w_ready = 1;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (w_valid !== 1'b1 || w_data !== 64'hA000_0000_0000_00A0 + 64'(i) ||
          w_strb !== (8'hF0 | 8'(i)) || w_user !== 6'(i + 1) || w_last !== (i == 2)) begin
        n_fail++;
        $display("FAIL w_beat%0d: got v=%b d=%h s=%h u=%0d l=%b", i, w_valid, w_data, w_strb, w_user, w_last); end
      @(posedge clk); @(negedge clk);
    end
    w_ready = 0;
    n_tests++; if (w_valid !== 1'b0 || w_rp !== 8'h08) begin n_fail++;
      $display("FAIL w_drain: got v=%b rp=%h want v=0 rp=08", w_valid, w_rp); end
  endtask

  task automatic test_mid_reset();
    ar_da = ax_word(32'h2000_0000, 6'd7, 6'd1, 8'd0, 3'd2, 2'd1, 2'b00, 4'd0, 3'd0, 4'd0, 4'd0);
    ar_wt = 8'h04; ar_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++; if (ar_valid !== 1'b1 || ar_id !== 6'd7) begin n_fail++;
      $display("FAIL ar_stream_valid: got v=%b id=%0d want v=1 id=7", ar_valid, ar_id); end
    ar_ready = 1;
    @(posedge clk); @(negedge clk);
    n_tests++; if (ar_rp !== 8'h02 || ar_valid !== 1'b1) begin n_fail++;
      $display("FAIL ar_stream_mid: got rp=%h v=%b want rp=02 v=1", ar_rp, ar_valid); end
    rst_ni = 0;
    aw_wt = 8'h01; ar_wt = 8'h01; w_wt = 8'h01; r_rp = 8'h01; b_rp = 8'h01; ar_ready = 0;
    #1;
    n_tests++; if (ar_valid !== 1'b0 || ar_rp !== 8'h01) begin n_fail++;
      $display("FAIL ar_reset_immediate: got v=%b rp=%h want v=0 rp=01", ar_valid, ar_rp); end
    repeat (2) @(negedge clk);
    n_tests++; if ({aw_rp, ar_rp, w_rp, r_wt, b_wt} !== {5{8'h01}}) begin n_fail++;
      $display("FAIL reset2_ptrs: got %h want 0101010101", {aw_rp, ar_rp, w_rp, r_wt, b_wt}); end
    rst_ni = 1;
    @(posedge clk); @(negedge clk);
    n_tests++; if ({aw_valid, ar_valid, w_valid, r_ready, b_ready} !== 5'b00011) begin n_fail++;
      $display("FAIL reset2_handshake: got %b want 00011", {aw_valid, ar_valid, w_valid, r_ready, b_ready}); end
    n_tests++; if (r_da !== '0 || b_da !== '0) begin n_fail++;
      $display("FAIL reset2_buffers: got r=%h b=%h want 0", r_da, b_da); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_aw();
    test_b_full();
    test_r_wrap();
    test_w_stall();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
